// File: rtl/sisc_fetch.sv
// SISC instruction fetch stage: PC, IR and the instruction-memory handshake.
// Branch targets from execute redirect the PC directly or at the end of a fetch.
`timescale 1ns/1ps
module sisc_fetch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              fetch_req,
  input  logic              br_taken,
  input  logic              br_rel,
  input  logic [ADDR_W-1:0] br_imm,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr,
  output logic [3:0]        opcode,
  output logic [3:0]        mm,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_valid,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_HLT = 4'hF;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              halt_q, halt_d;
  logic              pend_q, pend_d;
  logic              bpend_q, bpend_d;
  logic [ADDR_W-1:0] btgt_q, btgt_d;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] tgt_idle;
  logic [ADDR_W-1:0] tgt_wait;
  logic              fetch_go;

  // In WAIT the PC still points at the word in flight, so relative
  // targets are taken from the next instruction's address.
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign tgt_idle = br_rel ? pc_q + br_imm : br_imm;
  assign tgt_wait = br_rel ? pc_inc + br_imm : br_imm;
  assign fetch_go = fetch_req | pend_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    halt_d  = halt_q;
    pend_d  = pend_q;
    bpend_d = bpend_q;
    btgt_d  = btgt_q;
    unique case (state_q)
      S_IDLE: begin
        if (br_taken) begin
          pc_d   = tgt_idle;
          pend_d = fetch_go;
        end else if (fetch_go) begin
          pend_d  = 1'b0;
          rd_d    = 1'b1;
          addr_d  = pc_q;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (br_taken) begin
          bpend_d = 1'b1;
          btgt_d  = tgt_wait;
        end
        if (imem_ack) begin
          ir_d    = imem_data;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          rd_d    = 1'b0;
          bpend_d = 1'b0;
          if (br_taken)
            pc_d = tgt_wait;
          else if (bpend_q)
            pc_d = btgt_q;
          else
            pc_d = pc_inc;
          if (imem_data[DATA_W-1 -: 4] == OP_HLT) begin
            halt_d  = 1'b1;
            state_d = S_HALT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      halt_q  <= 1'b0;
      pend_q  <= 1'b0;
      bpend_q <= 1'b0;
      btgt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      halt_q  <= halt_d;
      pend_q  <= pend_d;
      bpend_q <= bpend_d;
      btgt_q  <= btgt_d;
    end
  end

  assign imem_rd   = rd_q;
  assign imem_addr = addr_q;
  assign instr     = ir_q;
  assign opcode    = ir_q[DATA_W-1 -: 4];
  assign mm        = ir_q[DATA_W-5 -: 4];
  assign pc        = pc_q;
  assign ir_valid  = valid_q;
  assign busy      = busy_q;
  assign halted    = halt_q;

endmodule
